// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples PC, runs a req/ack read on instruction
// memory and latches the returned word into IR, flagging fetch faults.
module instr_fetch_unit #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ALIGN = 2'b01;
    localparam logic [1:0] FC_BASE  = 2'b10;
    localparam logic [1:0] FC_TMO   = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   ir_q, ir_d;
    logic          irv_q, irv_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        irv_d   = 1'b0;
        code_d  = code_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    addr_d = pc;
                    // Alignment is checked before the segment bound.
                    if (pc[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                        code_d  = FC_ALIGN;
                    end else if (pc < TEXT_BASE) begin
                        state_d = S_FAULT;
                        code_d  = FC_BASE;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (imem_ack) begin
                    ir_d    = imem_rdata;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    state_d = S_FAULT;
                    code_d  = FC_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= TEXT_BASE;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ir         = ir_q;
    assign ir_valid   = irv_q;
    assign busy       = (state_q == S_REQ);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (instance uses TIMEOUT=4).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int n_cmp;
    int n_bad;

    instr_fetch_unit #(
        .TEXT_BASE(32'h0000_3000),
        .TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fault     (fault),
        .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_en   = 1'b0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc         = '0;
        rst        = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: req=%b busy=%b irv=%b want 0 0 0",
                     imem_req, busy, ir_valid);
        end
        n_cmp++;
        if (imem_addr !== 32'h0000_3000 || ir !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h ir=%h want 00003000 00000000",
                     imem_addr, ir);
        end
        n_cmp++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_fault: fault=%b code=%b want 0 00",
                     fault, fault_code);
        end
    endtask

    task automatic test_basic_fetch();
        int reqs;
        int pulses;
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3000;
        fetch_en = 1'b1;
        reqs     = 0;
        pulses   = 0;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req === 1'b1) reqs++;
            if (ir_valid === 1'b1) pulses++;
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h2008_0005;
            end
            if (i == 3) begin
                n_cmp++;
                if (ir !== 32'h2008_0005 || ir_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL basic_ir: ir=%h irv=%b want 20080005 1",
                             ir, ir_valid);
                end
            end
            tick();
            imem_ack = 1'b0;
        end
        n_cmp++;
        if (reqs != 3) begin
            n_bad++;
            $display("FAIL basic_req_len: got %0d want 3", reqs);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL basic_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3000;
        fetch_en = 1'b1;
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            n_bad++;
            $display("FAIL b2b_req1: req=%b addr=%h want 1 00003000",
                     imem_req, imem_addr);
        end
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_0001;
        tick();
        n_cmp++;
        if (ir_valid !== 1'b1 || ir !== 32'hAAAA_0001 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ack1: irv=%b ir=%h busy=%b want 1 aaaa0001 0",
                     ir_valid, ir, busy);
        end
        imem_ack = 1'b0;
        pc       = 32'h0000_3004;
        fetch_en = 1'b1;
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004 ||
            ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_req2: req=%b addr=%h irv=%b want 1 00003004 0",
                     imem_req, imem_addr, ir_valid);
        end
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBBBB_0002;
        tick();
        imem_ack = 1'b0;
        n_cmp++;
        if (ir_valid !== 1'b1 || ir !== 32'hBBBB_0002) begin
            n_bad++;
            $display("FAIL b2b_ack2: irv=%b ir=%h want 1 bbbb0002",
                     ir_valid, ir);
        end
    endtask

    task automatic test_faults();
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3002;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || imem_req !== 1'b0 ||
            imem_addr !== 32'h0000_3002) begin
            n_bad++;
            $display("FAIL misalign: f=%b c=%b req=%b addr=%h want 1 01 0 3002",
                     fault, fault_code, imem_req, imem_addr);
        end
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_1000;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0 ||
            imem_addr !== 32'h0000_1000) begin
            n_bad++;
            $display("FAIL below_base: f=%b c=%b req=%b addr=%h want 1 10 0 1000",
                     fault, fault_code, imem_req, imem_addr);
        end
        // Misaligned and below base together must report misalignment.
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_0001;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (fault_code !== 2'b01) begin
            n_bad++;
            $display("FAIL fault_prio: code=%b want 01", fault_code);
        end
    endtask

    task automatic test_timeout();
        int reqs;
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3010;
        fetch_en = 1'b1;
        reqs     = 0;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req === 1'b1) reqs++;
            tick();
        end
        n_cmp++;
        if (reqs != 4) begin
            n_bad++;
            $display("FAIL tmo_len: got %0d want 4", reqs);
        end
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 2'b11 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_fault: f=%b c=%b busy=%b want 1 11 0",
                     fault, fault_code, busy);
        end
        pc       = 32'h0000_3000;
        fetch_en = 1'b1;
        flush    = 1'b1;
        imem_ack = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0 || fault !== 1'b1 || fault_code !== 2'b11 ||
            ir_valid !== 1'b0 || imem_addr !== 32'h0000_3010) begin
            n_bad++;
            $display("FAIL tmo_sticky: req=%b f=%b c=%b irv=%b addr=%h",
                     imem_req, fault, fault_code, ir_valid, imem_addr);
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3000;
        fetch_en = 1'b1;
        tick();
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        pc       = 32'h0000_3008;
        fetch_en = 1'b1;
        tick();
        fetch_en   = 1'b0;
        flush      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        flush    = 1'b0;
        imem_ack = 1'b0;
        n_cmp++;
        if (ir !== 32'h1111_1111 || ir_valid !== 1'b0 || busy !== 1'b0 ||
            imem_req !== 1'b0 || fault !== 1'b0) begin
            n_bad++;
            $display("FAIL flush: ir=%h irv=%b busy=%b req=%b f=%b",
                     ir, ir_valid, busy, imem_req, fault);
        end
        pc       = 32'h0000_300C;
        fetch_en = 1'b1;
        tick();
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        tick();
        imem_ack = 1'b0;
        n_cmp++;
        if (ir !== 32'h2222_2222 || ir_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_refetch: ir=%h irv=%b want 22222222 1",
                     ir, ir_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        pc       = 32'h0000_3000;
        fetch_en = 1'b1;
        tick();
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_3333;
        tick();
        imem_ack = 1'b0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || ir !== 32'h3333_3333) begin
            n_bad++;
            $display("FAIL arst_pre: req=%b ir=%h want 1 33333333",
                     imem_req, ir);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || ir !== 32'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL arst: req=%b ir=%h busy=%b want 0 0 0",
                     imem_req, ir, busy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_faults();
        test_timeout();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
